// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: encodes symbolic MIPS instruction tuples into 32-bit
// words, buffers them in a small FIFO and writes them into instruction memory
// at sequential addresses. Used by the boot/bench path to preload programs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; no tuples accepted, no writes issued
// S_LOAD  | accepting tuples, writing buffered words to imem
// S_DRAIN | last tuple accepted; writing out whatever is still buffered
// S_DONE  | single-cycle end-of-session marker (done = 1, busy = 1)
module inst_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [31:0] enc_word;
  logic        enc_legal;

  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;

  logic accept;
  logic push;
  logic pop;
  logic start_ok;
  logic wrap;

  // Encode the presented tuple; unused fields of each format are ignored.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_kind)
      3'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      3'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      3'd2:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      3'd3:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
      3'd4:    enc_word = {6'h08, in_rs, in_rt, in_imm};
      3'd5:    enc_word = {6'h04, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // FIFO status: the extra pointer bit separates full from empty.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  end

  // Next-state decode and stream/memory handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    start_ok   = 1'b0;
    imem_wdata = fifo_mem[rd_ptr[PTR_W-1:0]];
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        // Ready only on free space, never on a same-cycle pop.
        in_ready = ~fifo_full;
        imem_we  = ~fifo_empty;
        if (in_valid && !fifo_full && in_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        imem_we = ~fifo_empty;
        if (fifo_empty) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    accept = in_valid & in_ready;
    push   = accept & enc_legal;
    pop    = imem_we & imem_ready;
    wrap   = pop && (imem_addr == ADDR_MAX);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FIFO storage and pointers; a simultaneous push and pop both take effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (start_ok) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
          wr_ptr <= wr_ptr + (PTR_W+1)'(1);
        end
        if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Write address, session word count and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= BASE_A;
      word_count <= '0;
      err        <= 1'b0;
    end else if (start_ok) begin
      imem_addr  <= BASE_A;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      if (pop) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        if (word_count != CNT_MAX) word_count <= word_count + (ADDR_W+1)'(1);
      end
      // Illegal kinds and address wrap both flag an error but keep loading.
      if ((accept && !enc_legal) || wrap) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: a table of encodings plus hand-written
// sequences for back-pressure, illegal kinds, address wrap and mid-session reset.
// A second instance with ADDR_W=2 shares the inputs to exercise wrap/saturation.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        imem_ready = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;

  logic        in_ready, imem_we, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        in_ready2, imem_we2, busy2, done2, err2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  word_count2;

  inst_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  inst_encoder_loader #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we2), .imem_ready(imem_ready), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .busy(busy2), .done(done2), .err(err2), .word_count(word_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  int total = 0;
  int bad = 0;

  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [1:0]  log_addr2[$];
  logic [7:0]  exp_a[$];
  logic [31:0] exp_d[$];

  // Record every memory write; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
    if (rst_n && imem_we2 && imem_ready) log_addr2.push_back(imem_addr2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_addr2.delete();
    exp_a.delete(); exp_d.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic last);
    int n;
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(name, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string tag);
    chk($sformatf("%s_nwrites", tag), log_data.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < log_data.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), {24'd0, log_addr[i]}, {24'd0, exp_a[i]});
        chk($sformatf("%s_data%0d", tag, i), log_data[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 32'h00221820};
    tbl[1] = '{3'd1, 5'd4,  5'd5,  5'd6,  16'hFFFF, 32'h0085302A};
    tbl[2] = '{3'd2, 5'd0,  5'd8,  5'd0,  16'h0004, 32'h8C080004};
    tbl[3] = '{3'd3, 5'd0,  5'd8,  5'd0,  16'h0008, 32'hAC080008};
    tbl[4] = '{3'd4, 5'd0,  5'd1,  5'd31, 16'h0005, 32'h20010005};
    tbl[5] = '{3'd5, 5'd1,  5'd2,  5'd0,  16'hFFFF, 32'h1022FFFF};
    tbl[6] = '{3'd0, 5'd31, 5'd31, 5'd31, 16'h1234, 32'h03FFF820};
    tbl[7] = '{3'd2, 5'd31, 5'd0,  5'd0,  16'h8000, 32'h8FE08000};

    // reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_wc", {23'd0, word_count}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;

    // in_valid in IDLE is not accepted
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // single add: latency, DRAIN length, done timing
    clear_logs();
    do_start();
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
    @(negedge clk);
    chk("t1_we", {31'd0, imem_we}, 32'd1);
    chk("t1_addr", {24'd0, imem_addr}, 32'd0);
    chk("t1_wdata", imem_wdata, 32'h00221820);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("t1_drain_done", {31'd0, done}, 32'd0);
    chk("t1_drain_busy", {31'd0, busy}, 32'd1);
    chk("t1_drain_we", {31'd0, imem_we}, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_done_busy", {31'd0, busy}, 32'd1);
    chk("t1_wc", {23'd0, word_count}, 32'd1);
    @(negedge clk);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("t1_nwrites", log_data.size(), 32'd1);

    // table of encodings in one session, back-to-back
    clear_logs();
    do_start();
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, (i == 7));
      exp_a.push_back(8'(i));
      exp_d.push_back(tbl[i].exp);
    end
    wait_done("tbl_done");
    check_log("tbl");
    chk("tbl_wc", {23'd0, word_count}, 32'd8);
    chk("tbl_err", {31'd0, err}, 32'd0);
    chk("tbl_wc2_sat", {29'd0, word_count2}, 32'd7);
    chk("tbl_err2", {31'd0, err2}, 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < log_addr2.size()) chk($sformatf("tbl_addr2_%0d", i), {30'd0, log_addr2[i]}, i % 4);

    // back-pressure: FIFO fills after 4, held stable, then drains in order
    clear_logs();
    imem_ready = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) send(3'd4, 5'd0, 5'(i), 5'd0, 16'(i), 1'b0);
    in_valid = 1'b1; in_kind = 3'd4; in_rs = 5'd0; in_rt = 5'd4; in_imm = 16'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_wdata%0d", c), imem_wdata, 32'h20000000);
      chk($sformatf("bp_addr%0d", c), {24'd0, imem_addr}, 32'd0);
    end
    chk("bp_nwrites_stall", log_data.size(), 32'd0);
    @(posedge clk); #1;
    imem_ready = 1'b1;
    send(3'd4, 5'd0, 5'd4, 5'd0, 16'd4, 1'b0);
    send(3'd4, 5'd0, 5'd5, 5'd0, 16'd5, 1'b1);
    wait_done("bp_done");
    for (int i = 0; i < 6; i++) begin
      exp_a.push_back(8'(i));
      exp_d.push_back(32'h20000000 | (i << 16) | i);
    end
    check_log("bp");

    // illegal kind between two addi
    clear_logs();
    do_start();
    send(3'd4, 5'd0, 5'd1, 5'd0, 16'd5, 1'b0);
    send(3'd6, 5'd3, 5'd3, 5'd3, 16'd7, 1'b0);
    send(3'd4, 5'd0, 5'd1, 5'd0, 16'd5, 1'b1);
    wait_done("ill_done");
    exp_a.push_back(8'd0); exp_d.push_back(32'h20010005);
    exp_a.push_back(8'd1); exp_d.push_back(32'h20010005);
    check_log("ill");
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_wc", {23'd0, word_count}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("ill_err_sticky", {31'd0, err}, 32'd1);
    do_start();
    chk("ill_err_cleared", {31'd0, err}, 32'd0);
    clear_logs();
    send(3'd7, 5'd1, 5'd1, 5'd1, 16'd1, 1'b1);
    wait_done("ill_last_done");
    chk("ill_last_err", {31'd0, err}, 32'd1);
    chk("ill_last_wc", {23'd0, word_count}, 32'd0);
    chk("ill_last_nwrites", log_data.size(), 32'd0);

    // address wrap on the 2-bit instance
    clear_logs();
    do_start();
    for (int i = 0; i < 5; i++) send(3'd0, 5'd1, 5'd1, 5'(i), 16'd0, (i == 4));
    wait_done("wrap_done");
    chk("wrap_nwrites2", log_addr2.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < log_addr2.size()) chk($sformatf("wrap_addr2_%0d", i), {30'd0, log_addr2[i]}, i % 4);
    chk("wrap_err2", {31'd0, err2}, 32'd1);
    chk("wrap_wc2", {29'd0, word_count2}, 32'd5);
    chk("wrap_err_main", {31'd0, err}, 32'd0);
    chk("wrap_addr_main", {24'd0, imem_addr}, 32'd5);

    // reset during DRAIN with two words queued
    imem_ready = 1'b0;
    do_start();
    send(3'd4, 5'd0, 5'd1, 5'd0, 16'd1, 1'b0);
    send(3'd4, 5'd0, 5'd2, 5'd0, 16'd2, 1'b1);
    @(negedge clk);
    chk("rd_busy_before", {31'd0, busy}, 32'd1);
    chk("rd_we_before", {31'd0, imem_we}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rd_busy", {31'd0, busy}, 32'd0);
    chk("rd_we", {31'd0, imem_we}, 32'd0);
    chk("rd_addr", {24'd0, imem_addr}, 32'd0);
    chk("rd_wc", {23'd0, word_count}, 32'd0);
    chk("rd_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rd_we_after", {31'd0, imem_we}, 32'd0);
    chk("rd_busy_after", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
